// File: rtl/spram512x128_port_ctrl.sv
// Single-port SRAM initiator: arbitrates write/read requests onto one port and
// returns read data in order through a 3-entry credit-protected response FIFO.
module spram512x128_port_ctrl #(
    parameter int AW = 9,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rdata_valid,
    input  logic          rdata_ready,
    output logic [DW-1:0] rdata,
    output logic          sram_ceb,
    output logic          sram_web,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    typedef enum logic {PRIO_RD = 1'b0, PRIO_WR = 1'b1} prio_t;

    prio_t         prio;
    logic          inflight;
    logic [1:0]    fifo_count;
    logic [1:0]    wptr;
    logic [1:0]    rptr;
    logic [DW-1:0] fifo_mem [3];

    logic [2:0]    outstanding;
    logic          rd_can;
    logic          rd_contend;
    logic          wr_fire;
    logic          rd_fire;
    logic          push;
    logic          pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the read sitting in the SRAM pipeline plus queued responses,
    // so every accepted read is guaranteed a FIFO slot without looking at rdata_ready.
    assign outstanding = {2'b00, inflight} + {1'b0, fifo_count};
    assign rd_can      = (outstanding < 3'd3);
    assign rd_contend  = rd_valid & rd_can;

    assign wr_ready = rst_n & ~(rd_contend & (prio == PRIO_RD));
    assign rd_ready = rst_n & rd_can & ~(wr_valid & (prio == PRIO_WR));

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    assign sram_ceb = ~(wr_fire | rd_fire);
    assign sram_web = ~wr_fire;
    assign sram_a   = wr_fire ? wr_addr : (rd_fire ? rd_addr : '0);
    assign sram_d   = wr_fire ? wr_data : '0;

    assign rdata_valid = (fifo_count != 2'd0);
    assign rdata       = rdata_valid ? fifo_mem[rptr] : '0;

    assign push = inflight;
    assign pop  = rdata_valid & rdata_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= PRIO_RD;
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
            wptr       <= 2'd0;
            rptr       <= 2'd0;
        end else begin
            inflight <= rd_fire;
            if (wr_valid & rd_contend)
                prio <= (prio == PRIO_RD) ? PRIO_WR : PRIO_RD;
            if (push)
                wptr <= ptr_inc(wptr);
            if (pop)
                rptr <= ptr_inc(rptr);
            if (push & ~pop)
                fifo_count <= fifo_count + 2'd1;
            else if (pop & ~push)
                fifo_count <= fifo_count - 2'd1;
        end
    end

    // Response storage holds data only; validity lives in fifo_count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= sram_q;
    end

endmodule

// File: tb/tb_spram512x128_port_ctrl.sv
// Directed and random checks of spram512x128_port_ctrl against a behavioural
// 512x128 SRAM and a reference memory with an in-order response queue.
module tb_spram512x128_port_ctrl;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [8:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [8:0]   rd_addr;
    logic         rdata_valid;
    logic         rdata_ready;
    logic [127:0] rdata;
    logic         sram_ceb;
    logic         sram_web;
    logic [8:0]   sram_a;
    logic [127:0] sram_d;
    logic [127:0] sram_q;

    logic [127:0] sram_mem [512];
    logic [127:0] ref_mem  [512];
    logic [127:0] exp_q [$];
    logic         inflight_m;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] D0 = 128'h0000_0000_1111_1111_2222_2222_3333_3333;
    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_0001_FFFF_0000_1234_5678;
    localparam logic [127:0] D3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] D4 = 128'h5A5A_A5A5_5A5A_A5A5_0F0F_F0F0_0F0F_F0F0;

    spram512x128_port_ctrl #(.AW(9), .DW(128)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .sram_ceb    (sram_ceb),
        .sram_web    (sram_web),
        .sram_a      (sram_a),
        .sram_d      (sram_d),
        .sram_q      (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: write-through to array, Q updated one edge after a read.
    initial sram_q = '0;
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    function automatic logic [127:0] pat(input int i);
        logic [31:0] x;
        x = 32'(i);
        return {32'hC0DE_0000 ^ x, 32'h1234_5678 ^ (x << 4), ~x, x * 32'd3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input int a, input logic [127:0] d);
        wr_valid = 1'b1;
        wr_addr  = 9'(a);
        wr_data  = d;
        #1;
        chk1("wr_word_ready", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, completion required");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rdata_ready = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        inflight_m = 1'b0;
        tick(); tick();

        // Reset state with requests pending
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 9'd3; rd_addr = 9'd4; wr_data = D2;
        #1;
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_rd_ready", rd_ready, 1'b0);
        chk1("rst_ceb", sram_ceb, 1'b1);
        chk1("rst_web", sram_web, 1'b1);
        chk1("rst_rdata_valid", rdata_valid, 1'b0);
        chkw("rst_rdata", rdata, '0);
        wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        #1;
        chkw("rst_sram_a", 128'(sram_a), '0);
        chkw("rst_sram_d", sram_d, '0);
        tick();
        rst_n = 1'b1;
        tick();

        wr_word(0, D0); wr_word(1, D2); wr_word(2, D3); wr_word(3, D4);

        // Basic write then read of address 5
        wr_valid = 1'b1; wr_addr = 9'd5; wr_data = D1;
        #1;
        chk1("basic_wr_ready", wr_ready, 1'b1);
        chk1("basic_wr_ceb", sram_ceb, 1'b0);
        chk1("basic_wr_web", sram_web, 1'b0);
        chkw("basic_wr_a", 128'(sram_a), 128'd5);
        chkw("basic_wr_d", sram_d, D1);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5; rdata_ready = 1'b1;
        #1;
        chk1("basic_rd_ready", rd_ready, 1'b1);
        chk1("basic_rd_ceb", sram_ceb, 1'b0);
        chk1("basic_rd_web", sram_web, 1'b1);
        chkw("basic_rd_a", 128'(sram_a), 128'd5);
        tick();
        rd_valid = 1'b0;
        #1;
        chk1("basic_lat1_valid", rdata_valid, 1'b0);
        tick();
        chk1("basic_lat2_valid", rdata_valid, 1'b1);
        chkw("basic_rdata", rdata, D1);
        tick();
        chk1("basic_drained", rdata_valid, 1'b0);

        // Backpressure: only three reads accepted while responses are held
        rdata_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1; rd_addr = 9'(i);
            #1;
            chk1("bp_accept_ready", rd_ready, 1'b1);
            tick();
        end
        rd_addr = 9'd3;
        #1;
        chk1("bp_full_ready", rd_ready, 1'b0);
        tick();
        chk1("bp_full_ready2", rd_ready, 1'b0);
        chk1("bp_head_valid", rdata_valid, 1'b1);
        chkw("bp_head0", rdata, D0);
        rdata_ready = 1'b1;
        #1;
        chk1("bp_no_comb_path", rd_ready, 1'b0);
        tick();
        chk1("bp_reopen_ready", rd_ready, 1'b1);
        chkw("bp_head1", rdata, D2);
        tick();
        rd_valid = 1'b0;
        chkw("bp_head2", rdata, D3);
        tick();
        chk1("bp_head3_valid", rdata_valid, 1'b1);
        chkw("bp_head3", rdata, D4);
        tick();
        chk1("bp_empty", rdata_valid, 1'b0);

        // Contention: grants alternate starting with read
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; rd_valid = 1'b1;
            wr_addr = 9'(100 + i); wr_data = pat(100 + i); rd_addr = 9'd5;
            #1;
            chk1("cont_rd_ready", rd_ready, (i % 2) == 0);
            chk1("cont_wr_ready", wr_ready, (i % 2) == 1);
            chk1("cont_ceb", sram_ceb, 1'b0);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        tick(); tick(); tick();
        chk1("cont_drained", rdata_valid, 1'b0);

        // Streaming: fill memory, then 512 back-to-back reads
        for (int i = 0; i < 512; i++) begin
            wr_word(i, pat(i));
            ref_mem[i] = pat(i);
        end
        for (int i = 0; i < 514; i++) begin
            rd_valid = (i < 512);
            rd_addr  = 9'(i);
            #1;
            if (i < 512) chk1("stream_rd_ready", rd_ready, 1'b1);
            if (i >= 2) begin
                chk1("stream_valid", rdata_valid, 1'b1);
                chkw("stream_rdata", rdata, pat(i - 2));
            end
            tick();
        end
        rd_valid = 1'b0;
        #1;
        chk1("stream_end_valid", rdata_valid, 1'b0);

        // Reset one cycle after a read handshake
        rd_valid = 1'b1; rd_addr = 9'd7;
        #1;
        chk1("mid_rd_ready", rd_ready, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", rdata_valid, 1'b0);
        chk1("mid_rst_ceb", sram_ceb, 1'b1);
        chk1("mid_rst_rd_ready", rd_ready, 1'b0);
        tick();
        chk1("mid_rst_valid2", rdata_valid, 1'b0);
        rd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk1("mid_post_valid", rdata_valid, 1'b0);
        tick();
        chk1("mid_post_valid2", rdata_valid, 1'b0);
        rd_valid = 1'b1; rd_addr = 9'd9;
        #1;
        chk1("mid_new_rd_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        #1;
        chk1("mid_new_lat1", rdata_valid, 1'b0);
        tick();
        chk1("mid_new_lat2", rdata_valid, 1'b1);
        chkw("mid_new_rdata", rdata, pat(9));
        tick();

        // Random traffic against the reference model
        inflight_m = 1'b0;
        for (int c = 0; c < 440; c++) begin
            logic wf, rf, ev;
            if (c < 400) begin
                wr_valid    = 1'($urandom_range(0, 1));
                rd_valid    = 1'($urandom_range(0, 1));
                wr_addr     = 9'($urandom_range(0, 15));
                rd_addr     = 9'($urandom_range(0, 15));
                wr_data     = {$urandom, $urandom, $urandom, $urandom};
                rdata_ready = ($urandom_range(0, 3) != 0);
            end else begin
                wr_valid = 1'b0; rd_valid = 1'b0; rdata_ready = 1'b1;
            end
            #1;
            wf = wr_valid & wr_ready;
            rf = rd_valid & rd_ready;
            ev = (exp_q.size() > int'(inflight_m));
            chk1("rand_exclusive", wf & rf, 1'b0);
            chk1("rand_credit", rd_ready & (exp_q.size() >= 3), 1'b0);
            chk1("rand_valid", rdata_valid, ev);
            if (ev && rdata_ready) begin
                chkw("rand_rdata", rdata, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (rf) exp_q.push_back(ref_mem[rd_addr]);
            if (wf) ref_mem[wr_addr] = wr_data;
            inflight_m = rf;
            tick();
        end
        chkw("rand_queue_empty", 128'(exp_q.size()), '0);
        chk1("rand_final_valid", rdata_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
